// File: rtl/ysyx_041514_alu_mul_ctrl_if.sv
// Interface of the multiply controller: issue, writeback and multiplier-request
// channels. The controller uses the slave modport; its environment uses master.
interface ysyx_041514_alu_mul_ctrl_if #(
  parameter int XLEN = 64
);
  logic              op_valid_i;
  logic [2:0]        op_type_i;
  logic [XLEN-1:0]   rs1_data_i;
  logic [XLEN-1:0]   rs2_data_i;
  logic              op_ready_o;
  logic              flush_i;
  logic              result_valid_o;
  logic              result_ready_i;
  logic [XLEN-1:0]   result_o;
  logic              mul_valid_o;
  logic              rs1_signed_valid_o;
  logic              rs2_signed_valid_o;
  logic [XLEN-1:0]   rs1_data_o;
  logic [XLEN-1:0]   rs2_data_o;
  logic              mul_ready_i;
  logic [2*XLEN-1:0] mul_out_i;

  modport slave (
    input  op_valid_i, op_type_i, rs1_data_i, rs2_data_i, flush_i,
           result_ready_i, mul_ready_i, mul_out_i,
    output op_ready_o, result_valid_o, result_o, mul_valid_o,
           rs1_signed_valid_o, rs2_signed_valid_o, rs1_data_o, rs2_data_o
  );

  modport master (
    output op_valid_i, op_type_i, rs1_data_i, rs2_data_i, flush_i,
           result_ready_i, mul_ready_i, mul_out_i,
    input  op_ready_o, result_valid_o, result_o, mul_valid_o,
           rs1_signed_valid_o, rs2_signed_valid_o, rs1_data_o, rs2_data_o
  );
endinterface

// File: rtl/ysyx_041514_alu_mul_ctrl.sv
// Multiply-op controller: issues requests to an external multiplier, keeps a
// one-entry product cache to skip repeated products, and handles flush/drain.
module ysyx_041514_alu_mul_ctrl #(
  parameter int XLEN = 64
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_041514_alu_mul_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  state_t            state_q, state_d;
  logic [2:0]        type_q, type_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic              mul_valid_q, mul_valid_d;
  logic              result_valid_q, result_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              cache_valid_q, cache_valid_d;
  logic [XLEN-1:0]   cache_rs1_q, cache_rs1_d, cache_rs2_q, cache_rs2_d;
  logic              cache_s1_q, cache_s1_d, cache_s2_q, cache_s2_d;
  logic [2*XLEN-1:0] cache_prod_q, cache_prod_d;

  logic in_s1, in_s2, in_illegal, hit;

  function automatic logic [XLEN-1:0] sel_result(input logic [2:0] t,
                                                 input logic [2*XLEN-1:0] p);
    case (t)
      OP_MUL:                       sel_result = p[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: sel_result = p[2*XLEN-1:XLEN];
      OP_MULW:                      sel_result = {{(XLEN-32){p[31]}}, p[31:0]};
      default:                      sel_result = '0;
    endcase
  endfunction

  always_comb begin
    in_illegal = (bus.op_type_i > OP_MULW);
    in_s1      = (bus.op_type_i != OP_MULHU) && !in_illegal;
    in_s2      = (bus.op_type_i != OP_MULHU) && (bus.op_type_i != OP_MULHSU) && !in_illegal;
    hit        = cache_valid_q && (cache_rs1_q == bus.rs1_data_i) &&
                 (cache_rs2_q == bus.rs2_data_i) && (cache_s1_q == in_s1) &&
                 (cache_s2_q == in_s2);

    state_d        = state_q;
    type_d         = type_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    s1_d           = s1_q;
    s2_d           = s2_q;
    mul_valid_d    = mul_valid_q;
    result_valid_d = result_valid_q;
    result_d       = result_q;
    cache_valid_d  = cache_valid_q;
    cache_rs1_d    = cache_rs1_q;
    cache_rs2_d    = cache_rs2_q;
    cache_s1_d     = cache_s1_q;
    cache_s2_d     = cache_s2_q;
    cache_prod_d   = cache_prod_q;

    case (state_q)
      IDLE: begin
        if (bus.flush_i) begin
          cache_valid_d = 1'b0;
        end else if (bus.op_valid_i) begin
          type_d = bus.op_type_i;
          rs1_d  = bus.rs1_data_i;
          rs2_d  = bus.rs2_data_i;
          s1_d   = in_s1;
          s2_d   = in_s2;
          if (in_illegal) begin
            result_d       = '0;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else if (hit) begin
            result_d       = sel_result(bus.op_type_i, cache_prod_q);
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            mul_valid_d = 1'b1;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.flush_i) begin
          cache_valid_d = 1'b0;
          // A response arriving with the flush is simply dropped; waiting in
          // DRAIN for another one would never end.
          if (bus.mul_ready_i) begin
            mul_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (bus.mul_ready_i) begin
          cache_valid_d  = 1'b1;
          cache_rs1_d    = rs1_q;
          cache_rs2_d    = rs2_q;
          cache_s1_d     = s1_q;
          cache_s2_d     = s2_q;
          cache_prod_d   = bus.mul_out_i;
          result_d       = sel_result(type_q, bus.mul_out_i);
          result_valid_d = 1'b1;
          mul_valid_d    = 1'b0;
          state_d        = DONE;
        end
      end
      DRAIN: begin
        if (bus.mul_ready_i) begin
          mul_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      DONE: begin
        if (bus.flush_i) begin
          cache_valid_d  = 1'b0;
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end else if (bus.result_ready_i) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      type_q         <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      mul_valid_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      cache_valid_q  <= 1'b0;
      cache_rs1_q    <= '0;
      cache_rs2_q    <= '0;
      cache_s1_q     <= 1'b0;
      cache_s2_q     <= 1'b0;
      cache_prod_q   <= '0;
    end else begin
      state_q        <= state_d;
      type_q         <= type_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      mul_valid_q    <= mul_valid_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      cache_valid_q  <= cache_valid_d;
      cache_rs1_q    <= cache_rs1_d;
      cache_rs2_q    <= cache_rs2_d;
      cache_s1_q     <= cache_s1_d;
      cache_s2_q     <= cache_s2_d;
      cache_prod_q   <= cache_prod_d;
    end
  end

  assign bus.op_ready_o         = (state_q == IDLE);
  assign bus.result_valid_o     = result_valid_q;
  assign bus.result_o           = result_q;
  assign bus.mul_valid_o        = mul_valid_q;
  assign bus.rs1_signed_valid_o = s1_q;
  assign bus.rs2_signed_valid_o = s2_q;
  assign bus.rs1_data_o         = rs1_q;
  assign bus.rs2_data_o         = rs2_q;
endmodule

// File: doc/ysyx_041514_alu_mul_ctrl.md
YSYX_041514_ALU_MUL_CTRL -- requirements
Module: ysyx_041514_alu_mul_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width; the product is 2*XLEN.
REQ-002 SHALL have port clk  input  1  the single clock; all flops on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port op_valid_i  input  1  the issue stage offers a multiply op.
REQ-005 SHALL have port op_type_i  input  3  op code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 illegal.
REQ-006 SHALL have ports rs1_data_i / rs2_data_i  input  XLEN  source operands.
REQ-007 SHALL have port op_ready_o  output  1  the block accepts an op this cycle.
REQ-008 SHALL have port flush_i  input  1  pipeline flush; the in-flight op is discarded.
REQ-009 SHALL have port result_valid_o  output  1  result_o is valid.
REQ-010 SHALL have port result_ready_i  input  1  the writeback consumer accepts the result.
REQ-011 SHALL have port result_o  output  XLEN  final multiply result.
REQ-012 SHALL have ports mul_valid_o, rs1_signed_valid_o, rs2_signed_valid_o (output, 1 each) and rs1_data_o, rs2_data_o (output, XLEN): the request to the multiplier.
REQ-013 SHALL have ports mul_ready_i  input  1 and mul_out_i  input  2*XLEN: the multiplier response.

Function
REQ-014 SHALL implement the states IDLE, BUSY, DRAIN and DONE; op_ready_o = (state==IDLE).
REQ-015 SHALL accept an op when op_valid_i && op_ready_o && !flush_i, registering the operands, the type and the sign flags in that cycle.
REQ-016 SHALL set the sign flags as follows: MUL/MULH/MULW (1,1), MULHSU (1,0), MULHU (0,0).
REQ-017 SHALL keep a one-entry product cache (valid bit, rs1, rs2, s1, s2, 2*XLEN product), written on every completed multiplier response that is not discarded.
REQ-018 SHALL treat an accept as a cache hit when the cache is valid and all four keys match; a hit goes IDLE->DONE with result_valid_o high the next cycle (latency 1) and no multiplier request.
REQ-019 SHALL treat an accepted op with an illegal type (5-7) as a hit with result 0, with no multiplier request and no cache change.
REQ-020 SHALL move a cache miss IDLE->BUSY; in BUSY, mul_valid_o=1 and the operands/flags are held stable until mul_ready_i is sampled high.
REQ-021 SHALL treat mul_ready_i high in BUSY as meaning mul_out_i is valid in that cycle: the block SHALL update the cache, register the selected result, and go to DONE; mul_valid_o SHALL be 0 from the next cycle.
REQ-022 SHALL select the result as: MUL prod[XLEN-1:0]; MULH/MULHSU/MULHU prod[2*XLEN-1:XLEN]; MULW sign-extension of prod[31:0].
REQ-023 SHALL hold result_valid_o and result_o stable in DONE until result_ready_i, then go to IDLE; an op SHALL be accepted no earlier than the cycle after the handshake.
REQ-024 SHALL, on flush_i: from IDLE or DONE, go to IDLE with result_valid_o dropped; from BUSY, go to DRAIN. In all cases the cache SHALL be invalidated.
REQ-025 SHALL, in DRAIN, keep mul_valid_o=1, wait for mul_ready_i, discard the product (no cache write), then go to IDLE; flush_i in DRAIN has no further effect.
REQ-026 SHALL give flush_i priority over result_ready_i and over op acceptance in the same cycle.
REQ-027 SHALL drive mul_valid_o only in BUSY and DRAIN and keep it 0 otherwise.

Reset
REQ-028 SHALL, while rst is asserted: state=IDLE, cache valid=0, result_valid_o=0, mul_valid_o=0, result_o=0, rs1_data_o/rs2_data_o=0, sign flags 0; asserting rst mid-operation SHALL abandon everything immediately, and the multiplier is reset by the same rst.

Verification
REQ-029 SHALL be covered by: MUL rs1=3, rs2=-2 (miss) -> one mul_valid_o burst, flags (1,1), result_o=0xFFFF_FFFF_FFFF_FFFA, held until result_ready_i.
REQ-030 SHALL be covered by: MUL then MULH with rs1=-1, rs2=-1 -> the second op is a hit, result_valid_o 1 cycle after accept, result_o=0, no mul_valid_o.
REQ-031 SHALL be covered by: MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> miss, flags (0,0), result_o=0xFFFF_FFFF_FFFF_FFFE.
REQ-032 SHALL be covered by: MULW rs1=0x8000_0000, rs2=1 -> result_o=0xFFFF_FFFF_8000_0000.
REQ-033 SHALL be covered by: flush_i in BUSY -> DRAIN, op_ready_o=0 until mul_ready_i, no result_valid_o, and the next identical op misses.
REQ-034 SHALL be covered by: op_type=6 -> result_o=0 after 1 cycle; and rst asserted in BUSY -> all outputs 0 asynchronously, op_ready_o=1 after release.
